// File: rtl/interrupt_ctrl.sv
// Prioritised interrupt controller: latches source edges, filters by mask/gie,
// and presents one vectored request at a time to the control unit.
module interrupt_ctrl #(
    parameter int              N_SRC    = 4,
    parameter int              VEC_W    = 8,
    parameter logic [VEC_W-1:0] VEC_BASE = 8'hF0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             gie_set,
    input  logic             gie_clr,
    input  logic             int_ack,
    input  logic             iret,
    output logic             intp,
    output logic [VEC_W-1:0] int_vec,
    output logic             in_service,
    output logic [N_SRC-1:0] pending
);

    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [N_SRC-1:0]   irq_prev_r;
    logic [N_SRC-1:0]   pending_r, pending_nxt_s;
    logic [N_SRC-1:0]   mask_r, mask_nxt_s;
    logic               gie_r, gie_nxt_s;
    logic [SEL_W-1:0]   sel_r, sel_nxt_s;
    logic               intp_r, intp_nxt_s;
    logic               in_service_r, in_service_nxt_s;
    logic [VEC_W-1:0]   int_vec_r, int_vec_nxt_s;
    logic [N_SRC-1:0]   edge_s, eligible_s, clr_s;
    logic [SEL_W-1:0]   pick_s;
    logic               found_s;

    function automatic logic [VEC_W-1:0] vec_of(input logic [SEL_W-1:0] idx);
        return VEC_BASE + VEC_W'(idx);
    endfunction

    assign edge_s     = irq & ~irq_prev_r;
    assign eligible_s = pending_r & mask_r;

    // Lowest-index eligible source; scanning downward lets index 0 win.
    always_comb begin
        pick_s  = '0;
        found_s = |eligible_s;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            pick_s = eligible_s[i] ? SEL_W'(i) : pick_s;
        end
    end

    // Next-state, request/service outputs, gie and pending updates.
    always_comb begin
        state_nxt_s      = state_r;
        sel_nxt_s        = sel_r;
        intp_nxt_s       = intp_r;
        in_service_nxt_s = in_service_r;
        int_vec_nxt_s    = int_vec_r;
        clr_s            = '0;
        if (gie_clr) begin
            gie_nxt_s = 1'b0;
        end else if (gie_set) begin
            gie_nxt_s = 1'b1;
        end else begin
            gie_nxt_s = gie_r;
        end
        case (state_r)
            ST_IDLE: begin
                intp_nxt_s       = 1'b0;
                in_service_nxt_s = 1'b0;
                int_vec_nxt_s    = '0;
                if (gie_r && found_s) begin
                    state_nxt_s   = ST_REQ;
                    sel_nxt_s     = pick_s;
                    intp_nxt_s    = 1'b1;
                    int_vec_nxt_s = vec_of(pick_s);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    clr_s[sel_r]     = 1'b1;
                    gie_nxt_s        = 1'b0;
                    intp_nxt_s       = 1'b0;
                    in_service_nxt_s = 1'b1;
                    int_vec_nxt_s    = vec_of(sel_r);
                    state_nxt_s      = ST_SERVICE;
                end else if (gie_clr) begin
                    intp_nxt_s    = 1'b0;
                    int_vec_nxt_s = '0;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    intp_nxt_s    = 1'b1;
                    int_vec_nxt_s = vec_of(sel_r);
                end
            end
            ST_SERVICE: begin
                // iret restores gie regardless of any gie_clr seen meanwhile.
                if (iret) begin
                    gie_nxt_s        = 1'b1;
                    in_service_nxt_s = 1'b0;
                    int_vec_nxt_s    = '0;
                    state_nxt_s      = ST_IDLE;
                end else begin
                    in_service_nxt_s = 1'b1;
                    int_vec_nxt_s    = vec_of(sel_r);
                end
            end
            default: begin
                state_nxt_s      = ST_IDLE;
                intp_nxt_s       = 1'b0;
                in_service_nxt_s = 1'b0;
                int_vec_nxt_s    = '0;
            end
        endcase
        // A fresh edge on the acknowledged source survives its own clear.
        pending_nxt_s = (pending_r & ~clr_s) | edge_s;
        if (mask_we) begin
            mask_nxt_s = mask_wdata;
        end else begin
            mask_nxt_s = mask_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            irq_prev_r   <= '0;
            pending_r    <= '0;
            mask_r       <= '0;
            gie_r        <= 1'b0;
            sel_r        <= '0;
            intp_r       <= 1'b0;
            in_service_r <= 1'b0;
            int_vec_r    <= '0;
        end else begin
            state_r      <= state_nxt_s;
            irq_prev_r   <= irq;
            pending_r    <= pending_nxt_s;
            mask_r       <= mask_nxt_s;
            gie_r        <= gie_nxt_s;
            sel_r        <= sel_nxt_s;
            intp_r       <= intp_nxt_s;
            in_service_r <= in_service_nxt_s;
            int_vec_r    <= int_vec_nxt_s;
        end
    end

    assign intp       = intp_r;
    assign int_vec    = int_vec_r;
    assign in_service = in_service_r;
    assign pending    = pending_r;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl; expectations are queued before each
// stimulus step and popped against the DUT outputs after it.
module tb_interrupt_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       gie_set, gie_clr, int_ack, iret;
    logic       intp;
    logic [7:0] int_vec;
    logic       in_service;
    logic [3:0] pending;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    interrupt_ctrl dut (
        .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .gie_set(gie_set), .gie_clr(gie_clr), .int_ack(int_ack), .iret(iret),
        .intp(intp), .int_vec(int_vec), .in_service(in_service), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we = 1'b1; mask_wdata = m;
        step();
        mask_we = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1; step(); int_ack = 1'b0;
    endtask

    task automatic pulse_iret();
        iret = 1'b1; step(); iret = 1'b0;
    endtask

    initial begin
        rst = 1'b0; irq = 4'b1111; mask_we = 1'b0; mask_wdata = 4'b0000;
        gie_set = 1'b0; gie_clr = 1'b0; int_ack = 1'b0; iret = 1'b0;

        // Reset values with all lines high
        exp("rst_intp", 32'd0); exp("rst_vec", 32'd0); exp("rst_insvc", 32'd0); exp("rst_pend", 32'd0);
        #12;
        chk(32'(intp)); chk(32'(int_vec)); chk(32'(in_service)); chk(32'(pending));
        rst = 1'b1;
        exp("rel_pend", 32'hF); exp("rel_intp", 32'd0);
        step();
        chk(32'(pending)); chk(32'(intp));
        exp("rel_intp2", 32'd0);
        step();
        chk(32'(intp));

        // Clean restart
        irq = 4'b0000;
        rst = 1'b0; #2; rst = 1'b1;
        step();

        // Single source
        mask_we = 1'b1; mask_wdata = 4'b0100; gie_set = 1'b1;
        step();
        mask_we = 1'b0; gie_set = 1'b0;
        irq = 4'b0100;
        exp("ss_pend_e0", 32'h4); exp("ss_intp_e0", 32'd0);
        step();
        chk(32'(pending)); chk(32'(intp));
        exp("ss_intp", 32'd1); exp("ss_vec", 32'hF2);
        step();
        chk(32'(intp)); chk(32'(int_vec));
        exp("ss_ack_intp", 32'd0); exp("ss_ack_insvc", 32'd1); exp("ss_ack_pend", 32'd0); exp("ss_ack_vec", 32'hF2);
        pulse_ack();
        chk(32'(intp)); chk(32'(in_service)); chk(32'(pending)); chk(32'(int_vec));
        exp("ss_iret_insvc", 32'd0); exp("ss_iret_intp", 32'd0); exp("ss_iret_vec", 32'd0);
        pulse_iret();
        chk(32'(in_service)); chk(32'(intp)); chk(32'(int_vec));

        // Priority: irq[3] and irq[1] together, gie restored by iret
        write_mask(4'b1111);
        irq = 4'b1110;
        exp("pr_pend", 32'hA); exp("pr_intp0", 32'd0);
        step();
        chk(32'(pending)); chk(32'(intp));
        exp("pr_intp1", 32'd1); exp("pr_vec1", 32'hF1);
        step();
        chk(32'(intp)); chk(32'(int_vec));
        exp("pr_ack_pend", 32'h8); exp("pr_ack_insvc", 32'd1);
        pulse_ack();
        chk(32'(pending)); chk(32'(in_service));
        exp("pr_iret_insvc", 32'd0); exp("pr_gap_intp", 32'd0);
        pulse_iret();
        chk(32'(in_service)); chk(32'(intp));
        exp("pr_intp3", 32'd1); exp("pr_vec3", 32'hF3);
        step();
        chk(32'(intp)); chk(32'(int_vec));
        pulse_ack();
        pulse_iret();

        // Masked pending, then withdraw by gie_clr
        write_mask(4'b0000);
        irq = 4'b0000;
        step();
        irq = 4'b0001;
        exp("mk_pend", 32'h1);
        step();
        chk(32'(pending));
        for (int i = 0; i < 10; i++) begin
            exp("mk_intp_hold", 32'd0);
            step();
            chk(32'(intp));
        end
        exp("mk_wr_intp", 32'd0);
        write_mask(4'b0001);
        chk(32'(intp));
        exp("mk_intp", 32'd1); exp("mk_vec", 32'hF0);
        step();
        chk(32'(intp)); chk(32'(int_vec));
        exp("wd_intp", 32'd0); exp("wd_pend", 32'h1); exp("wd_vec", 32'd0);
        gie_clr = 1'b1; step(); gie_clr = 1'b0;
        chk(32'(intp)); chk(32'(pending)); chk(32'(int_vec));
        exp("wd_gie_off", 32'd0);
        step();
        chk(32'(intp));
        exp("wd_set_intp", 32'd0);
        gie_set = 1'b1; step(); gie_set = 1'b0;
        chk(32'(intp));
        exp("wd_re_intp", 32'd1); exp("wd_re_vec", 32'hF0);
        step();
        chk(32'(intp)); chk(32'(int_vec));
        pulse_ack();
        pulse_iret();

        // Edge on acknowledged source wins; new edge during service waits
        write_mask(4'b1111);
        irq = 4'b0000;
        step();
        irq = 4'b0100;
        step();
        irq = 4'b0000;
        exp("sc_intp", 32'd1); exp("sc_vec", 32'hF2);
        step();
        chk(32'(intp)); chk(32'(int_vec));
        irq = 4'b0100;
        exp("sc_ack_insvc", 32'd1); exp("sc_ack_pend", 32'h4); exp("sc_ack_intp", 32'd0);
        pulse_ack();
        chk(32'(in_service)); chk(32'(pending)); chk(32'(intp));
        irq = 4'b0110;
        exp("sc_svc_pend", 32'h6); exp("sc_svc_intp", 32'd0);
        step();
        chk(32'(pending)); chk(32'(intp));
        exp("sc_svc_intp2", 32'd0); exp("sc_svc_insvc", 32'd1);
        step();
        chk(32'(intp)); chk(32'(in_service));
        exp("sc_iret_intp", 32'd0); exp("sc_iret_insvc", 32'd0);
        pulse_iret();
        chk(32'(intp)); chk(32'(in_service));
        exp("sc_next_intp", 32'd1); exp("sc_next_vec", 32'hF1);
        step();
        chk(32'(intp)); chk(32'(int_vec));
        pulse_ack();
        pulse_iret();
        exp("sc_last_intp", 32'd1); exp("sc_last_vec", 32'hF2);
        step();
        chk(32'(intp)); chk(32'(int_vec));
        exp("sc_last_pend", 32'h0);
        pulse_ack();
        chk(32'(pending));
        pulse_iret();

        // gie_set with gie_clr: clear wins
        gie_set = 1'b1; gie_clr = 1'b1; step(); gie_set = 1'b0; gie_clr = 1'b0;
        irq = 4'b0000;
        step();
        irq = 4'b1000;
        exp("gc_pend", 32'h8);
        step();
        chk(32'(pending));
        for (int i = 0; i < 3; i++) begin
            exp("gc_intp_off", 32'd0);
            step();
            chk(32'(intp));
        end
        gie_set = 1'b1; step(); gie_set = 1'b0;
        exp("gc_intp", 32'd1); exp("gc_vec", 32'hF3);
        step();
        chk(32'(intp)); chk(32'(int_vec));

        // Asynchronous reset in REQ
        #2;
        rst = 1'b0;
        exp("ar_intp", 32'd0); exp("ar_pend", 32'd0); exp("ar_insvc", 32'd0); exp("ar_vec", 32'd0);
        #1;
        chk(32'(intp)); chk(32'(pending)); chk(32'(in_service)); chk(32'(int_vec));
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
